// File: rtl/radix4_online_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : radix4_online_mul_seq
// Description : Sequencer for a digit-serial radix-4 online multiplier.
//               Accepts a parallel operand pair and streams it MSD first, one
//               digit per cycle. It then zero-fills the inputs for the online
//               delay and collects N result digits into a parallel word.
// Options     : ONLINE_SEQ_B2B_EN - when defined, a new operand pair can be
//               accepted on the same edge that the result is taken.
// Revision    : 1.0 - initial release
// ============================================================================
module radix4_online_mul_seq #(
   parameter int NO_OF_DIGITS = 4,
   parameter int RADIX_BITS   = 3,
   parameter int RADIX        = 4,
   parameter int DELTA        = 2
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [NO_OF_DIGITS*RADIX_BITS-1:0]   in_x,
   input  logic [NO_OF_DIGITS*RADIX_BITS-1:0]   in_y,
   output logic [RADIX_BITS-1:0]                mul_x,
   output logic [RADIX_BITS-1:0]                mul_y,
   output logic                                 mul_start,
   input  logic [RADIX_BITS-1:0]                mul_z,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [NO_OF_DIGITS*RADIX_BITS-1:0]   out_z,
   output logic                                 busy
);

   localparam int c_W      = NO_OF_DIGITS * RADIX_BITS;
   localparam int c_LAST   = NO_OF_DIGITS + DELTA - 1;
   localparam int c_CNT_W  = (c_LAST > 1) ? $clog2(c_LAST + 1) : 1;

   localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(c_LAST);
   localparam logic [c_CNT_W-1:0] c_CNT_DELTA = c_CNT_W'(DELTA);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

   // RADIX only documents the number system; the datapath depends solely on
   // the digit width, so this block never holds any logic.
   if (RADIX < 2) begin : g_radix_doc_only
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic                  w_load;

   logic [c_W-1:0]        r_sx;
   logic [c_W-1:0]        r_sy;
   logic [c_CNT_W-1:0]    r_cnt;
   logic [RADIX_BITS-1:0] r_mul_x;
   logic [RADIX_BITS-1:0] r_mul_y;
   logic                  r_mul_start;
   logic [c_W-1:0]        r_out_z;
   logic                  w_capture;

   // The result window opens once the online delay has elapsed.
   assign w_capture = (r_cnt >= c_CNT_DELTA);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode and handshake outputs.
   always_comb begin
      w_next_state = r_state;
      w_load       = 1'b0;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      busy         = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_load       = 1'b1;
               w_next_state = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (r_cnt == c_CNT_LAST) begin
               w_next_state = S_DONE;
            end
         end
         S_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
`ifdef ONLINE_SEQ_B2B_EN
            // The slot frees on the same edge the result leaves, so a
            // waiting operand pair can go straight into the next run.
            in_ready = out_ready;
            if (out_ready) begin
               if (in_valid) begin
                  w_load       = 1'b1;
                  w_next_state = S_RUN;
               end else begin
                  w_next_state = S_IDLE;
               end
            end
`else
            if (out_ready) begin
               w_next_state = S_IDLE;
            end
`endif
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // Operand shifting, digit output registers, counter and result capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sx        <= '0;
         r_sy        <= '0;
         r_cnt       <= '0;
         r_mul_x     <= '0;
         r_mul_y     <= '0;
         r_mul_start <= 1'b0;
         r_out_z     <= '0;
      end else if (w_load) begin
         // Digit 0 goes straight to the output register; the shift
         // registers keep the remaining digits with the next one on top.
         r_mul_x     <= in_x[c_W-1 -: RADIX_BITS];
         r_mul_y     <= in_y[c_W-1 -: RADIX_BITS];
         r_sx        <= in_x << RADIX_BITS;
         r_sy        <= in_y << RADIX_BITS;
         r_mul_start <= 1'b1;
         r_cnt       <= '0;
         r_out_z     <= '0;
      end else if (r_state == S_RUN) begin
         // Zeros shift in from the bottom, so once all digits are gone the
         // top field supplies the zero fill for the online delay.
         if (r_cnt == c_CNT_LAST) begin
            r_mul_x <= '0;
            r_mul_y <= '0;
         end else begin
            r_mul_x <= r_sx[c_W-1 -: RADIX_BITS];
            r_mul_y <= r_sy[c_W-1 -: RADIX_BITS];
         end
         r_sx        <= r_sx << RADIX_BITS;
         r_sy        <= r_sy << RADIX_BITS;
         r_mul_start <= 1'b0;
         r_cnt       <= r_cnt + c_CNT_ONE;
         if (w_capture) begin
            r_out_z <= {r_out_z[c_W-RADIX_BITS-1:0], mul_z};
         end
      end else begin
         // Idle or holding a result: the multiplier sees zero digits and
         // the result word is left untouched.
         r_mul_x     <= '0;
         r_mul_y     <= '0;
         r_mul_start <= 1'b0;
      end
   end

   assign mul_x     = r_mul_x;
   assign mul_y     = r_mul_y;
   assign mul_start = r_mul_start;
   assign out_z     = r_out_z;

endmodule
`default_nettype wire

// File: tb/tb_radix4_online_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_radix4_online_mul_seq
// Description : Self-checking bench for radix4_online_mul_seq. Three
//               instances (DELTA = 2, 0, 3) each run against an XOR stub
//               multiplier, so the expected result word is in_x ^ in_y.
//               Expected timing is derived from N and DELTA.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_radix4_online_mul_seq;

   localparam int N  = 4;
   localparam int RB = 3;
   localparam int W  = N * RB;

   typedef struct {
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic [W-1:0] z;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         iv_m = 1'b0;
   logic         iv_e = 1'b0;
   logic [W-1:0] x = '0;
   logic [W-1:0] y = '0;
   logic         ordy = 1'b0;

   logic          ir2, ov2, ms2, bz2, ir0, ov0, ms0, bz0, ir3, ov3, ms3, bz3;
   logic [RB-1:0] mx2, my2, mz2, mx0, my0, mz0, mx3, my3, mz3;
   logic [W-1:0]  oz2, oz0, oz3;
   logic [RB-1:0] p2a, p2b, p3a, p3b, p3c;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   radix4_online_mul_seq #(.NO_OF_DIGITS(N), .RADIX_BITS(RB), .RADIX(4), .DELTA(2)) u_d2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_m), .in_ready(ir2), .in_x(x), .in_y(y),
      .mul_x(mx2), .mul_y(my2), .mul_start(ms2), .mul_z(mz2),
      .out_valid(ov2), .out_ready(ordy), .out_z(oz2), .busy(bz2));

   radix4_online_mul_seq #(.NO_OF_DIGITS(N), .RADIX_BITS(RB), .RADIX(4), .DELTA(0)) u_d0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_e), .in_ready(ir0), .in_x(x), .in_y(y),
      .mul_x(mx0), .mul_y(my0), .mul_start(ms0), .mul_z(mz0),
      .out_valid(ov0), .out_ready(ordy), .out_z(oz0), .busy(bz0));

   radix4_online_mul_seq #(.NO_OF_DIGITS(N), .RADIX_BITS(RB), .RADIX(4), .DELTA(3)) u_d3 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv_e), .in_ready(ir3), .in_x(x), .in_y(y),
      .mul_x(mx3), .mul_y(my3), .mul_start(ms3), .mul_z(mz3),
      .out_valid(ov3), .out_ready(ordy), .out_z(oz3), .busy(bz3));

   // XOR stub multipliers with DELTA-cycle latency.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p2a <= '0; p2b <= '0; p3a <= '0; p3b <= '0; p3c <= '0;
      end else begin
         p2a <= mx2 ^ my2; p2b <= p2a;
         p3a <= mx3 ^ my3; p3b <= p3a; p3c <= p3b;
      end
   end
   assign mz2 = p2b;
   assign mz3 = p3c;
   assign mz0 = mx0 ^ my0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One operation on all three instances; checks latency and result word.
   task automatic run_op(input logic [W-1:0] ax, input logic [W-1:0] ay,
                         input logic [W-1:0] ez, input string tag);
      int lat[3];
      logic [W-1:0] z[3];
      int w;
      lat = '{-1, -1, -1};
      z = '{'0, '0, '0};
      w = 0;
      while (!(ir2 && ir0 && ir3) && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (w >= 50) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s idle wait: in_ready never returned", tag);
      end
      x = ax; y = ay; iv_m = 1'b1; iv_e = 1'b1; ordy = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) begin
            iv_m = 1'b0;
            iv_e = 1'b0;
         end
         if (ov2 && lat[0] < 0) begin lat[0] = k; z[0] = oz2; end
         if (ov0 && lat[1] < 0) begin lat[1] = k; z[1] = oz0; end
         if (ov3 && lat[2] < 0) begin lat[2] = k; z[2] = oz3; end
         if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
      end
      check({tag, " lat d2"}, lat[0], N + 2 + 1);
      check({tag, " lat d0"}, lat[1], N + 0 + 1);
      check({tag, " lat d3"}, lat[2], N + 3 + 1);
      check({tag, " z d2"}, 32'(z[0]), 32'(ez));
      check({tag, " z d0"}, 32'(z[1]), 32'(ez));
      check({tag, " z d3"}, 32'(z[2]), 32'(ez));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl[6];
      logic [RB-1:0] exp_dig[6];
      int acc[2];
      int nacc;
      int nres;
      int exp_gap;
      logic [W-1:0] rx, ry;

      tbl[0] = '{x: 12'o1234, y: 12'o0000, z: 12'o1234};
      tbl[1] = '{x: 12'o7777, y: 12'o1234, z: 12'o6543};
      tbl[2] = '{x: 12'o4444, y: 12'o0000, z: 12'o4444};
      tbl[3] = '{x: 12'o0000, y: 12'o0000, z: 12'o0000};
      tbl[4] = '{x: 12'o5252, y: 12'o2525, z: 12'o7777};
      tbl[5] = '{x: 12'o1000, y: 12'o1000, z: 12'o0000};
      exp_dig = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0};
`ifdef ONLINE_SEQ_B2B_EN
      exp_gap = N + 2 + 1;
`else
      exp_gap = N + 2 + 2;
`endif

      // Reset values.
      repeat (3) @(negedge clk);
      check("rst in_ready", in_ready_m(), 1);
      check("rst out_valid", ov2, 0);
      check("rst busy", bz2, 0);
      check("rst mul_x", mx2, 0);
      check("rst mul_start", ms2, 0);
      check("rst out_z", oz2, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post-rst in_ready", ir2, 1);

      // Digit order, zero fill, start pulse, latency.
      x = 12'o1234; y = 12'o0000; iv_m = 1'b1; ordy = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k == 1) iv_m = 1'b0;
         check($sformatf("digit %0d mul_x", k), mx2, exp_dig[k-1]);
         check($sformatf("digit %0d mul_start", k), ms2, (k == 1) ? 1 : 0);
         check($sformatf("digit %0d out_valid", k), ov2, 0);
         if (k == 3) begin
            check("run in_ready", ir2, 0);
            check("run busy", bz2, 1);
         end
      end
      @(negedge clk);
      check("done out_valid", ov2, 1);
      check("done out_z", 32'(oz2), 32'(12'o1234));
      check("done mul_x", mx2, 0);

      // Output backpressure.
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp out_valid", ov2, 1);
         check("bp out_z", 32'(oz2), 32'(12'o1234));
         check("bp in_ready", ir2, 0);
      end
      ordy = 1'b1;
      @(negedge clk);
      check("release out_valid", ov2, 0);
      check("release in_ready", ir2, 1);
      check("release busy", bz2, 0);

      // Asynchronous reset mid-run (cnt = 3).
      x = 12'o1234; y = 12'o0000; iv_m = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) iv_m = 1'b0;
      end
      check("pre-rst mul_x", mx2, 4);
      rst_n = 1'b0;
      #1;
      check("async rst mul_x", mx2, 0);
      check("async rst out_valid", ov2, 0);
      check("async rst in_ready", ir2, 1);
      check("async rst busy", bz2, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Continuous in_valid: acceptance spacing and both results.
      x = 12'o7654; y = 12'o1111; iv_m = 1'b1; ordy = 1'b1;
      nacc = 0; nres = 0; acc = '{0, 0};
      for (int c = 0; c < 30; c++) begin
         if (nacc == 2) iv_m = 1'b0;
         if (ov2) begin
            nres++;
            check("overlap out_z", 32'(oz2), 32'(12'o6745));
         end
         if (iv_m && ir2 && nacc < 2) begin
            acc[nacc] = c;
            nacc++;
         end
         @(negedge clk);
      end
      iv_m = 1'b0;
      check("overlap acceptances", nacc, 2);
      check("overlap spacing", acc[1] - acc[0], exp_gap);
      check("overlap results", nres, 2);

      // Table vectors.
      for (int i = 0; i < 6; i++) begin
         run_op(tbl[i].x, tbl[i].y, tbl[i].z, $sformatf("tbl%0d", i));
      end

      // Random vectors against the XOR reference.
      for (int i = 0; i < 30; i++) begin
         rx = W'($urandom);
         ry = W'($urandom);
         run_op(rx, ry, rx ^ ry, $sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   function automatic logic in_ready_m();
      return ir2;
   endfunction

endmodule
`default_nettype wire
